// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop synchronisers, a debounced 16-bit switch word,
// and one press FSM per button that emits a single-cycle strobe per accepted press.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | sync high, counting toward an accepted press
// HELD         | press accepted, waiting for a release
// RELEASE_WAIT | sync low, counting toward an accepted release
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buttonLRaw,
  input  logic        buttonRRaw,
  input  logic [15:0] switchRaw,
  output logic        buttonL,
  output logic        buttonR,
  output logic [15:0] switch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  logic [17:0]      meta;
  logic [17:0]      sync;
  logic [1:0]       btn_sync;
  logic [1:0]       btn_pulse;
  logic [15:0]      sw_sync;
  logic [15:0]      cand;
  logic [CNT_W-1:0] sw_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {buttonLRaw, buttonRRaw, switchRaw};
      sync <= meta;
    end
  end

  // bit 1 = left, bit 0 = right
  assign btn_sync = sync[17:16];
  assign sw_sync  = sync[15:0];

  // The whole word restarts its count on any bit change, so switch only ever loads a settled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      sw_cnt <= '0;
      switch <= '0;
    end else if (sw_sync != cand) begin
      cand   <= sw_sync;
      sw_cnt <= '0;
    end else if (sw_cnt == CNT_LAST) begin
      switch <= cand;
    end else begin
      sw_cnt <= sw_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse;
    logic             pulse_next;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
        pulse <= pulse_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
        IDLE: begin
          if (btn_sync[gi]) begin
            state_next = PRESS_WAIT;
            cnt_next   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync[gi])        state_next = IDLE;
          else if (cnt == CNT_LAST) state_next = HELD;
          else                      cnt_next   = cnt + CNT_W'(1);
        end
        HELD: begin
          if (!btn_sync[gi]) begin
            state_next = RELEASE_WAIT;
            cnt_next   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync[gi])         state_next = HELD;
          else if (cnt == CNT_LAST) state_next = IDLE;
          else                      cnt_next   = cnt + CNT_W'(1);
        end
        default: state_next = IDLE;
      endcase
    end

    always_comb begin
      pulse_next = (state == PRESS_WAIT) && btn_sync[gi] && (cnt == CNT_LAST);
    end

    assign btn_pulse[gi] = pulse;
  end

  assign buttonL = btn_pulse[1];
  assign buttonR = btn_pulse[0];

endmodule
